// File: rtl/wb_wait_slave.sv
// rtl/wb_wait_slave.sv - Wishbone classic responder with register-file memory and programmable wait states.
module wb_wait_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    output logic                    wb_ack_o,
    output logic                    wb_err_o,
    output logic [1:0]              state_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SEL_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    req;
    logic                    access;
    logic                    acc_we;
    logic [ADDR_WIDTH-1:0]   acc_adr;
    logic [DATA_WIDTH-1:0]   acc_dat;
    logic [SEL_W-1:0]        acc_sel;
    logic [IDX_W-1:0]        acc_idx;
    logic                    in_range;
    logic                    mem_we;

    assign req = wb_cyc_i & wb_stb_i;

    // With zero wait states the access happens at the capture edge, so the live bus is used directly.
    assign acc_we  = (state_q == ST_IDLE) ? wb_we_i  : we_q;
    assign acc_adr = (state_q == ST_IDLE) ? wb_adr_i : adr_q;
    assign acc_dat = (state_q == ST_IDLE) ? wb_dat_i : wdat_q;
    assign acc_sel = (state_q == ST_IDLE) ? wb_sel_i : sel_q;
    assign acc_idx = acc_adr[IDX_W-1:0];

    // Widened compare so every address bit, including those above the index, takes part.
    assign in_range = ({{(32-ADDR_WIDTH){1'b0}}, acc_adr} < 32'(DEPTH));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        access  = 1'b0;
        mem_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d   = wb_we_i;
                    adr_d  = wb_adr_i;
                    wdat_d = wb_dat_i;
                    sel_d  = wb_sel_i;
                    if (WAIT_STATES == 0) begin
                        access  = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = 4'(WAIT_STATES - 1);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (access) begin
            if (!in_range) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (acc_we) begin
                    mem_we = 1'b1;
                end else begin
                    rdat_d = mem[acc_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < SEL_W; i++) begin
                if (acc_sel[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_dat[8*i +: 8];
                end
            end
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_wb_wait_slave.sv
// tb/tb_wb_wait_slave.sv - Directed table-driven bench for wb_wait_slave with 2 and 0 wait states.
module tb_wb_wait_slave;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cyc, stb, we;
    logic [7:0]  adr;
    logic [31:0] dat_i;
    logic [3:0]  sel;
    logic [31:0] dat_o;
    logic        ack, err;
    logic [1:0]  state;

    logic        rst0, cyc0, stb0, we0;
    logic [7:0]  adr0;
    logic [31:0] dat_i0;
    logic [3:0]  sel0;
    logic [31:0] dat_o0;
    logic        ack0, err0;
    logic [1:0]  state0;

    wb_wait_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(2)) u_dut (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
        .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel), .wb_dat_o(dat_o),
        .wb_ack_o(ack), .wb_err_o(err), .state_o(state)
    );

    wb_wait_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst0), .wb_cyc_i(cyc0), .wb_stb_i(stb0), .wb_we_i(we0),
        .wb_adr_i(adr0), .wb_dat_i(dat_i0), .wb_sel_i(sel0), .wb_dat_o(dat_o0),
        .wb_ack_o(ack0), .wb_err_o(err0), .state_o(state0)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[11];

    // Full transaction on the 2-wait-state instance; expects response on the 3rd cycle after capture.
    task automatic txn(input string name, input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic e_ack, input logic e_err, input logic [31:0] e_dat);
        int lat;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            lat = k;
            if (ack || err) break;
            chk({name, " wait_state"}, {30'd0, state}, 32'd1);
        end
        chk({name, " latency"}, lat, 32'd3);
        chk({name, " resp_state"}, {30'd0, state}, 32'd2);
        chk({name, " ack"}, {31'd0, ack}, {31'd0, e_ack});
        chk({name, " err"}, {31'd0, err}, {31'd0, e_err});
        chk({name, " dat_o"}, dat_o, e_dat);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk({name, " back_idle"}, {30'd0, state}, 32'd0);
        chk({name, " ack_cleared"}, {30'd0, ack, err}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0; sel = '0;
        rst0 = 1'b1; cyc0 = 1'b0; stb0 = 1'b0; we0 = 1'b0; adr0 = '0; dat_i0 = '0; sel0 = '0;

        vecs[0]  = '{1'b1, 8'd5,   32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h00000000};
        vecs[1]  = '{1'b0, 8'd5,   32'h00000000, 4'h0, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 8'd5,   32'h11223344, 4'h5, 1'b1, 1'b0, 32'hDEADBEEF};
        vecs[3]  = '{1'b0, 8'd5,   32'h00000000, 4'hF, 1'b1, 1'b0, 32'hDE22BE44};
        vecs[4]  = '{1'b1, 8'd64,  32'h55555555, 4'hF, 1'b0, 1'b1, 32'hDE22BE44};
        vecs[5]  = '{1'b0, 8'd64,  32'h00000000, 4'hF, 1'b0, 1'b1, 32'hDE22BE44};
        vecs[6]  = '{1'b0, 8'd5,   32'h00000000, 4'hF, 1'b1, 1'b0, 32'hDE22BE44};
        vecs[7]  = '{1'b1, 8'd7,   32'hA5A5A5A5, 4'hF, 1'b1, 1'b0, 32'hDE22BE44};
        vecs[8]  = '{1'b1, 8'd63,  32'h0BADF00D, 4'hF, 1'b1, 1'b0, 32'hDE22BE44};
        vecs[9]  = '{1'b1, 8'd255, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 32'hDE22BE44};
        vecs[10] = '{1'b0, 8'd63,  32'h00000000, 4'h0, 1'b1, 1'b0, 32'h0BADF00D};

        repeat (2) @(negedge clk);
        rst = 1'b0; rst0 = 1'b0;
        @(negedge clk);
        chk("reset state", {30'd0, state}, 32'd0);
        chk("reset ack_err", {30'd0, ack, err}, 32'd0);
        chk("reset dat_o", dat_o, 32'd0);
        chk("reset0 state", {30'd0, state0}, 32'd0);
        chk("reset0 dat_o", dat_o0, 32'd0);

        for (int i = 0; i < 11; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                vecs[i].exp_ack, vecs[i].exp_err, vecs[i].exp_dat);
        end

        // Abort: strobe dropped in the first WAIT cycle of a write to adr 7.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'd7; dat_i = 32'h0; sel = 4'hF;
        @(negedge clk);
        chk("abort in_wait", {30'd0, state}, 32'd1);
        stb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort idle", {30'd0, state}, 32'd0);
            chk("abort no_resp", {30'd0, ack, err}, 32'd0);
        end
        cyc = 1'b0;
        txn("abort readback", 1'b0, 8'd7, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA5A5A5A5);

        // Bus changes during WAIT must not affect the latched request.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'd9; dat_i = 32'h12345678; sel = 4'hF;
        @(negedge clk);
        we = 1'b0; adr = 8'd7; dat_i = 32'h0; sel = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("latched ack", {30'd0, ack, err}, 32'd2);
        cyc = 1'b0; stb = 1'b0;
        txn("latched rd9", 1'b0, 8'd9, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12345678);
        txn("latched rd7", 1'b0, 8'd7, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA5A5A5A5);

        // Reset while in WAIT.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'd5;
        @(negedge clk);
        chk("rstwait in_wait", {30'd0, state}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwait state", {30'd0, state}, 32'd0);
        chk("rstwait ack_err", {30'd0, ack, err}, 32'd0);
        chk("rstwait dat_o", dat_o, 32'd0);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        txn("after rst rd5", 1'b0, 8'd5, 32'h0, 4'h0, 1'b1, 1'b0, 32'hDE22BE44);

        // Zero wait states: held request gives RESP, IDLE, RESP, IDLE.
        @(negedge clk);
        cyc0 = 1'b1; stb0 = 1'b1; we0 = 1'b1; adr0 = 8'd3; dat_i0 = 32'hCAFEF00D; sel0 = 4'hF;
        @(negedge clk);
        chk("ws0 resp1", {30'd0, state0}, 32'd2);
        chk("ws0 ack1", {30'd0, ack0, err0}, 32'd2);
        @(negedge clk);
        chk("ws0 idle1", {30'd0, state0}, 32'd0);
        chk("ws0 noack1", {30'd0, ack0, err0}, 32'd0);
        we0 = 1'b0;
        @(negedge clk);
        chk("ws0 resp2", {30'd0, state0}, 32'd2);
        chk("ws0 ack2", {30'd0, ack0, err0}, 32'd2);
        chk("ws0 rd dat", dat_o0, 32'hCAFEF00D);
        @(negedge clk);
        chk("ws0 idle2", {30'd0, state0}, 32'd0);
        adr0 = 8'd100;
        @(negedge clk);
        chk("ws0 err", {30'd0, ack0, err0}, 32'd1);
        chk("ws0 err dat", dat_o0, 32'hCAFEF00D);
        cyc0 = 1'b0; stb0 = 1'b0;
        @(negedge clk);
        chk("ws0 final idle", {30'd0, state0}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_wait_slave.md
Name: wb_wait_slave

Overview:
- Wishbone classic single-port responder (slave) with a register-file memory behind it.
- Inserts a programmable number of wait states before each acknowledge.
- Answers out-of-range addresses with an error instead of an acknowledge.
- Is the target-side counterpart of the bus initiator. Exposes its FSM state so the FSM property checks (valid transition, output-per-state, timeout) can bind to it directly.

Parameters:
- ADDR_WIDTH, 8, word-address width of wb_adr_i
- DATA_WIDTH, 32, data bus width; multiple of 8
- DEPTH, 64, number of implemented words; valid addresses 0..DEPTH-1
- WAIT_STATES, 2, idle cycles inserted between request capture and response; 0..15

Ports:
- clk  in  1  sample clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- wb_cyc_i  in  1  bus cycle in progress
- wb_stb_i  in  1  strobe, valid request
- wb_we_i  in  1  1=write, 0=read
- wb_adr_i  in  ADDR_WIDTH  word address
- wb_dat_i  in  DATA_WIDTH  write data
- wb_sel_i  in  DATA_WIDTH/8  byte-lane enables for writes
- wb_dat_o  out  DATA_WIDTH  read data (registered)
- wb_ack_o  out  1  normal termination, one-cycle pulse
- wb_err_o  out  1  error termination, one-cycle pulse
- state_o  out  2  FSM state: 0=IDLE, 1=WAIT, 2=RESP (3 unused)

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high; clock port is clk, reset port is rst.
- Reset values: state_o=IDLE, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, wait counter=0. Memory contents are not reset.
- Reset mid-transfer: returns to IDLE at the next edge with no memory write and no ack/err. It overrides all other events.

FSM:
- IDLE: on an edge with cyc&stb=1, latch adr/we/dat/sel.
  - WAIT_STATES=0: go to RESP and perform the access at that edge.
  - Otherwise: go to WAIT and load counter=WAIT_STATES-1.
- WAIT: each edge with cyc&stb=1 and counter!=0 decrements the counter.
  - When counter==0 and cyc&stb=1: perform the access and go to RESP.
  - If cyc=0 or stb=0 at any WAIT edge: abort to IDLE, with no access and no ack/err.
- RESP: wb_ack_o or wb_err_o is 1 for exactly this one cycle. The next edge always goes to IDLE; the bus inputs are ignored in RESP.
- State 3 (illegal): goes to IDLE at the next edge with outputs 0.

Output rules and latency:
- ack/err are Moore outputs of RESP only; they are never both 1, and both are 0 in IDLE and WAIT.
- Request first seen at edge N → ack/err high in the cycle after edge N+WAIT_STATES, i.e. WAIT_STATES+1 cycles of latency.
- Minimum spacing between accepted requests is WAIT_STATES+2 cycles, because IDLE lasts at least one cycle after RESP.
- The latched address, not the live wb_adr_i, is used for the access. Changes to adr/dat/we/sel during WAIT are ignored.

Access rules:
- Latched adr >= DEPTH: err=1, ack=0, no memory write, wb_dat_o unchanged.
- Write: only bytes with sel[i]=1 are updated; wb_dat_o unchanged.
- Read: wb_dat_o loads mem[adr] at the edge entering RESP and holds it until the next successful read. sel is ignored for reads.
- ADDR_WIDTH bits above log2(DEPTH) take part in the range check; there is no wrap-around or aliasing.

Timeout guarantee: the FSM never stays in WAIT for more than WAIT_STATES consecutive cycles, and never stays in RESP for more than 1 cycle.

Test Plan:
- Reset, then write adr=5, dat=0xDEADBEEF, sel=0xF, WAIT_STATES=2 → ack high exactly 3 cycles after request; state_o sequence 0,1,1,2,0. A read of adr 5 then returns 0xDEADBEEF with the same latency.
- Partial write adr=5, dat=0x11223344, sel=0b0101 → subsequent read returns 0xDE22BE44.
- Access adr=64 (DEPTH=64), write then read → err pulses for one cycle, ack stays 0, mem[5] unchanged, wb_dat_o keeps its prior value 0xDE22BE44.
- Drop wb_stb_i during the 1st WAIT cycle of a write to adr 7 → state returns to IDLE, no ack/err, later read of adr 7 shows the old value.
- Assert rst while in WAIT → next cycle state_o=0, ack=err=0, wb_dat_o=0. A new request afterwards completes normally with 3-cycle latency.
- Rebuild with WAIT_STATES=0 and issue back-to-back requests held on stb → ack in the cycle after each capture, one IDLE cycle between RESPs, state sequence 0,2,0,2.
